// File: rtl/check_memory.sv
// rtl/check_memory.sv - identity-pattern read-back checker for the S-array RAM (option: CHECK_MEMORY_STOP_ON_ERR_EN)
module check_memory #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] address_out,
  output logic              finish,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_bad_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t state, state_nx;

  // {valid, address} travelling alongside each outstanding read
  logic [READ_LATENCY-1:0] tap_v;
  logic [ADDR_W-1:0]       tap_a [READ_LATENCY];

  logic              tap_valid;
  logic [ADDR_W-1:0] tap_addr;
  logic              mismatch;
  logic              accept;
  logic [ADDR_W:0]   err_nx;

  assign tap_valid = tap_v[READ_LATENCY-1];
  assign tap_addr  = tap_a[READ_LATENCY-1];
  assign mismatch  = tap_valid && (data_in != DATA_W'(tap_addr));
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign err_nx    = err_count + (ADDR_W+1)'(mismatch);

  // Next-state decode; start is only honoured in IDLE and DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (address_out == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   if (tap_valid && (tap_addr == LAST_ADDR)) state_nx = DONE;
      DONE:    if (start) state_nx = ISSUE;
      default: state_nx = IDLE;
    endcase
`ifdef CHECK_MEMORY_STOP_ON_ERR_EN
    if (((state == ISSUE) || (state == DRAIN)) && mismatch) state_nx = DONE;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Registered status outputs follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en  <= 1'b0;
      finish <= 1'b0;
    end else begin
      rd_en  <= (state_nx == ISSUE);
      finish <= (state_nx == DONE);
    end
  end

  // Read address counter: restarts at 0 on start, stops at the top address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_out <= '0;
    end else if (accept) begin
      address_out <= '0;
    end else if ((state == ISSUE) && (state_nx == ISSUE)) begin
      address_out <= address_out + 1'b1;
    end
  end

  // Compare pipeline; entering DONE drops anything still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tap_a[i] <= '0;
    end else begin
      if (state_nx == DONE) begin
        tap_v <= '0;
      end else begin
        tap_v[0] <= (state == ISSUE);
        for (int i = 1; i < READ_LATENCY; i++) tap_v[i] <= tap_v[i-1];
      end
      tap_a[0] <= address_out;
      for (int i = 1; i < READ_LATENCY; i++) tap_a[i] <= tap_a[i-1];
    end
  end

  // Result accumulation: mismatch count, first failing address, final verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_bad_addr <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_count      <= '0;
      first_bad_addr <= '0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_nx;
        if (err_count == '0) first_bad_addr <= tap_addr;
      end
      if ((state_nx == DONE) && (state != DONE)) pass <= (err_nx == '0);
    end
  end

endmodule
